mem_wb_stage: RTL

Parametrised MEM→WB pipeline stage with a valid/ready handshake, flush, an optional skid buffer, and a writeback forwarding port. It sits between the memory stage and the register-file write port of the rv32i core. It replaces the free-running MEM/WB register with a stage that can stall, flush and report bubbles. The payload fields are mnemonic, destination register, result data and write enable.

---
 rtl/mem_wb_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB stage with valid/ready handshake, flush, forwarding port and bubble counter
// Optional 2-entry skid buffer compiled in with `define MEM_WB_SKID_EN
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int MNEM_W = 6,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [MNEM_W-1:0] i_mnemonic,
   input  logic [REG_AW-1:0] i_rd_addr,
   input  logic [DATA_W-1:0] i_ALUout,
   input  logic              i_rd_wr,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [MNEM_W-1:0] o_mnemonic,
   output logic [REG_AW-1:0] o_rd_addr,
   output logic [DATA_W-1:0] o_ALUout,
   output logic              o_rd_wr,
   input  logic              i_flush,
   output logic              o_fwd_valid,
   output logic [REG_AW-1:0] o_fwd_addr,
   output logic [DATA_W-1:0] o_fwd_data,
   input  logic              i_cnt_clr,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY,
      FULL
`ifdef MEM_WB_SKID_EN
      , SKID
`endif
   } state_t;

   state_t state, state_nx;
   logic   load_main;
   logic   main_we;
   logic   in_we;

   // x0 writes are squashed at capture so nothing downstream has to re-check
   assign in_we = i_rd_wr & (i_rd_addr != '0);

`ifdef MEM_WB_SKID_EN
   logic              load_skid;
   logic              main_from_skid;
   logic [MNEM_W-1:0] skid_mnemonic;
   logic [REG_AW-1:0] skid_rd_addr;
   logic [DATA_W-1:0] skid_ALUout;
   logic              skid_we;
`endif

   always_comb begin
      state_nx  = state;
      load_main = 1'b0;
`ifdef MEM_WB_SKID_EN
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
`endif
      if (i_flush) begin
         state_nx = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (i_valid) begin
                  load_main = 1'b1;
                  state_nx  = FULL;
               end
            end
            FULL: begin
               if (i_ready) begin
                  if (i_valid) load_main = 1'b1;
                  else         state_nx  = EMPTY;
               end
`ifdef MEM_WB_SKID_EN
               else if (i_valid) begin
                  load_skid = 1'b1;
                  state_nx  = SKID;
               end
`endif
            end
`ifdef MEM_WB_SKID_EN
            SKID: begin
               if (i_ready) begin
                  main_from_skid = 1'b1;
                  state_nx       = FULL;
               end
            end
`endif
            default: state_nx = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_mnemonic <= '0;
         o_rd_addr  <= '0;
         o_ALUout   <= '0;
         main_we    <= 1'b0;
      end else if (load_main) begin
         o_mnemonic <= i_mnemonic;
         o_rd_addr  <= i_rd_addr;
         o_ALUout   <= i_ALUout;
         main_we    <= in_we;
      end
`ifdef MEM_WB_SKID_EN
      else if (main_from_skid) begin
         o_mnemonic <= skid_mnemonic;
         o_rd_addr  <= skid_rd_addr;
         o_ALUout   <= skid_ALUout;
         main_we    <= skid_we;
      end
`endif
   end

`ifdef MEM_WB_SKID_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_mnemonic <= '0;
         skid_rd_addr  <= '0;
         skid_ALUout   <= '0;
         skid_we       <= 1'b0;
      end else if (load_skid) begin
         skid_mnemonic <= i_mnemonic;
         skid_rd_addr  <= i_rd_addr;
         skid_ALUout   <= i_ALUout;
         skid_we       <= in_we;
      end
   end
`endif

   assign o_valid = (state != EMPTY);

`ifdef MEM_WB_SKID_EN
   // Decoded from the state register only, so i_ready never reaches o_ready
   assign o_ready = (state != SKID);
`else
   assign o_ready = ~o_valid | i_ready;
`endif

   assign o_rd_wr     = main_we & o_valid;
   assign o_fwd_valid = o_rd_wr;
   assign o_fwd_addr  = o_rd_addr;
   assign o_fwd_data  = o_ALUout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 o_bubble_cnt <= '0;
      else if (i_cnt_clr)                      o_bubble_cnt <= '0;
      else if (!o_valid && o_bubble_cnt != '1) o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
   end

endmodule
